rx_word_aligner: RTL
====================

# rx_word_aligner

Receive-side byte aligner between the GT RX (8b/10b decoded, 4 bytes per clock, arbitrary byte rotation) and the data descrambler. Searches for the K28.5 comma, locks a byte offset after repeated consistent commas, and re-packs the stream so every comma lands in byte 0. Drives the descrambler enable: high only while locked, so the descrambler holds its seed until alignment is established.

## Interface
- P_COMMA, 8'hBC, comma byte value; qualified by its char flag
- P_LOCK_CNT, 4, consecutive same-lane commas needed to lock (2..15)
- P_LOSS_CNT, 4, consecutive wrong-lane commas that drop lock (1..15)

- i_clk  input  1  RX user clock
- i_rst  input  1  reset; asynchronous, active-low
- i_rx_data  input  32  decoded RX bytes; byte b = [8b+7:8b], byte 0 received first
- i_rx_char  input  4  K-char flag per byte
- i_rx_valid  input  1  word qualifier; low words are ignored entirely
- o_data  output  32  aligned data
- o_char  output  4  aligned K flags
- o_valid  output  1  aligned word valid
- o_lock  output  1  alignment locked
- o_scr_en  output  1  descrambler enable (= o_lock, registered together)
- o_offset  output  2  current byte offset

## Operation
- Comma detect, valid words only: lane b hits when i_rx_char[b]=1 and byte b = P_COMMA. Multiple hits: lowest lane wins. No hit: word carries no alignment information.
- Pipeline: valid words shift into prev register. Aligned word = ({cur_data, prev_data} >> 8*offset)[31:0]; char identical on the 8-bit {cur_char, prev_char} with shift = offset.
- FSM states SEARCH, CHECK, LOCKED; 4-bit match counter mcnt, 4-bit error counter ecnt.
  - SEARCH: comma at lane k -> offset<=k, mcnt<=1, go CHECK.
  - CHECK: comma at lane == offset -> mcnt+1; when mcnt+1 == P_LOCK_CNT go LOCKED, ecnt<=0. Comma at other lane k -> offset<=k, mcnt<=1, stay CHECK.
  - LOCKED: comma at lane == offset -> ecnt<=0. Comma at other lane -> ecnt+1; when ecnt+1 == P_LOSS_CNT go SEARCH (offset kept, mcnt<=0). Offset never changes while LOCKED.
  - Non-comma or invalid words: no state or counter change.
- o_valid = 1 only in LOCKED, for each valid input word, after prev holds a valid word. Outside LOCKED, o_data/o_char = 0, o_valid = 0.
- o_lock/o_scr_en high exactly while state == LOCKED (registered).

## Timing
- Reset (i_rst=0, async): state SEARCH, offset 0, mcnt 0, ecnt 0, prev 0; all outputs 0. Reset mid-lock drops o_lock/o_scr_en immediately (async). First comma after release is processed normally.
- Comma word at cycle t -> state update visible at t+1.
- Lock: the P_LOCK_CNT-th matching comma sampled at t -> o_lock=1 at t+1; o_valid may assert at t+1 for that word's aligned output.
- Data latency: valid input at t -> aligned word at t+1, formed with the previous valid word. Bytes from word n at offset k appear at the output cycle after word n+1 is accepted.
- i_rx_valid low: prev, outputs data held; o_valid=0 that cycle.
- Loss: the P_LOSS_CNT-th wrong-lane comma at t -> o_lock=0, o_valid=0 at t+1.
- Counters saturate by construction (compare before increment); no wrap.

## Test plan
- Reset: hold i_rst=0 with random inputs -> all outputs 0, o_offset=0; release, no commas for 100 cycles -> o_lock stays 0.
- Lock at offset 2: stream with byte 2 = BC/K every 8th word, 4 times -> o_lock=1 the cycle after 4th comma, o_offset=2, o_data[7:0]=8'hBC with o_char[0]=1 on every comma word, payload bytes in order.
- Inconsistent commas: commas at lanes 1,1,3,3,3,3 -> CHECK restarts at lane 3, lock after 6th comma, o_offset=3.
- Loss: locked at offset 0, 3 commas at lane 1 then one at lane 0 -> stays locked (ecnt cleared); then 4 commas at lane 1 -> o_lock=0 cycle after 4th, o_scr_en=0.
- Valid gaps: locked, toggle i_rx_valid randomly -> output equals ideal aligned stream with gaps removed, no byte dropped or duplicated.
- Async reset while LOCKED mid-word -> o_lock/o_valid drop immediately; relock after 4 commas at new offset 1.

Source files
------------

// File: rtl/rx_word_aligner_if.sv
// Word-stream interface between the GT RX decoder, the aligner and the descrambler.
// The master drives the RX word; the slave (the aligner) returns the re-packed word and lock status.
interface rx_word_aligner_if;
    logic [31:0] i_rx_data;
    logic [3:0]  i_rx_char;
    logic        i_rx_valid;
    logic [31:0] o_data;
    logic [3:0]  o_char;
    logic        o_valid;
    logic        o_lock;
    logic        o_scr_en;
    logic [1:0]  o_offset;

    modport master (
        output i_rx_data, i_rx_char, i_rx_valid,
        input  o_data, o_char, o_valid, o_lock, o_scr_en, o_offset
    );

    modport slave (
        input  i_rx_data, i_rx_char, i_rx_valid,
        output o_data, o_char, o_valid, o_lock, o_scr_en, o_offset
    );
endinterface

// File: rtl/rx_word_aligner.sv
// Comma-based byte aligner: locks a byte offset after repeated same-lane K28.5 commas and
// re-packs the 4-byte RX stream so each comma lands in byte 0; enables the descrambler while locked.
module rx_word_aligner #(
    parameter logic [7:0]  P_COMMA    = 8'hBC,
    parameter int unsigned P_LOCK_CNT = 4,
    parameter int unsigned P_LOSS_CNT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    rx_word_aligner_if.slave bus
);
    localparam int unsigned W_DATA = 32;
    localparam int unsigned N_LANE = 4;
    localparam int unsigned W_CNT  = 4;
    localparam int unsigned W_OFF  = 2;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [W_OFF-1:0]    offset_q, offset_d;
    logic [W_CNT-1:0]    mcnt_q, mcnt_d;
    logic [W_CNT-1:0]    ecnt_q, ecnt_d;
    logic [W_DATA-1:0]   prev_data_q;
    logic [N_LANE-1:0]   prev_char_q;
    logic                prev_vld_q;
    logic [W_DATA-1:0]   data_q, data_d;
    logic [N_LANE-1:0]   char_q, char_d;
    logic                valid_q, valid_d;
    logic                lock_q;

    logic                hit;
    logic [W_OFF-1:0]    lane;
    logic [2*W_DATA-1:0] cat_data;
    logic [2*N_LANE-1:0] cat_char;
    logic [W_DATA-1:0]   aligned_data;
    logic [N_LANE-1:0]   aligned_char;

    // Comma search; scanning downward leaves the lowest hitting lane in 'lane'.
    always_comb begin
        hit  = 1'b0;
        lane = '0;
        for (int b = N_LANE - 1; b >= 0; b--) begin
            if (bus.i_rx_char[b] && (bus.i_rx_data[8*b +: 8] == P_COMMA)) begin
                hit  = 1'b1;
                lane = W_OFF'(b);
            end
        end
    end

    // Alignment state machine; only valid comma words move it.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        mcnt_d   = mcnt_q;
        ecnt_d   = ecnt_q;
        if (bus.i_rx_valid && hit) begin
            unique case (state_q)
                SEARCH: begin
                    offset_d = lane;
                    mcnt_d   = W_CNT'(1);
                    state_d  = CHECK;
                end
                CHECK: begin
                    if (lane == offset_q) begin
                        mcnt_d = mcnt_q + W_CNT'(1);
                        if ((mcnt_q + W_CNT'(1)) == W_CNT'(P_LOCK_CNT)) begin
                            state_d = LOCKED;
                            ecnt_d  = '0;
                        end
                    end else begin
                        offset_d = lane;
                        mcnt_d   = W_CNT'(1);
                    end
                end
                LOCKED: begin
                    if (lane == offset_q) begin
                        ecnt_d = '0;
                    end else if ((ecnt_q + W_CNT'(1)) == W_CNT'(P_LOSS_CNT)) begin
                        state_d = SEARCH;
                        mcnt_d  = '0;
                        ecnt_d  = '0;
                    end else begin
                        ecnt_d = ecnt_q + W_CNT'(1);
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Byte re-pack across the previous and current word, using the offset in force after this word.
    assign cat_data = {bus.i_rx_data, prev_data_q};
    assign cat_char = {bus.i_rx_char, prev_char_q};

    always_comb begin
        aligned_data = cat_data[31:0];
        aligned_char = cat_char[3:0];
        unique case (offset_d)
            2'd0: begin aligned_data = cat_data[31:0];  aligned_char = cat_char[3:0]; end
            2'd1: begin aligned_data = cat_data[39:8];  aligned_char = cat_char[4:1]; end
            2'd2: begin aligned_data = cat_data[47:16]; aligned_char = cat_char[5:2]; end
            2'd3: begin aligned_data = cat_data[55:24]; aligned_char = cat_char[6:3]; end
            default: ;
        endcase
    end

    // Output word: zeroed outside lock, held across invalid cycles.
    always_comb begin
        data_d  = data_q;
        char_d  = char_q;
        valid_d = 1'b0;
        if (state_d != LOCKED) begin
            data_d = '0;
            char_d = '0;
        end else if (bus.i_rx_valid && prev_vld_q) begin
            data_d  = aligned_data;
            char_d  = aligned_char;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= SEARCH;
            offset_q    <= '0;
            mcnt_q      <= '0;
            ecnt_q      <= '0;
            prev_data_q <= '0;
            prev_char_q <= '0;
            prev_vld_q  <= 1'b0;
            data_q      <= '0;
            char_q      <= '0;
            valid_q     <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            mcnt_q   <= mcnt_d;
            ecnt_q   <= ecnt_d;
            data_q   <= data_d;
            char_q   <= char_d;
            valid_q  <= valid_d;
            lock_q   <= (state_d == LOCKED);
            if (bus.i_rx_valid) begin
                prev_data_q <= bus.i_rx_data;
                prev_char_q <= bus.i_rx_char;
                prev_vld_q  <= 1'b1;
            end
        end
    end

    assign bus.o_data   = data_q;
    assign bus.o_char   = char_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_lock   = lock_q;
    assign bus.o_scr_en = lock_q;
    assign bus.o_offset = offset_q;
endmodule
